// File: rtl/csa_reduce_pipe.sv
// Pipelined carry-save reduction tree: ROWS partial-product rows -> redundant sum/carry pair,
// with valid/ready backpressure and an optional registered carry-propagate stage.
module csa_reduce_pipe #(
  parameter int unsigned WIDTH            = 48,
  parameter int unsigned ROWS             = 9,
  parameter int unsigned LEVELS_PER_STAGE = 2,
  parameter int unsigned FINAL_ADD        = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ROWS*WIDTH-1:0]   rows_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        sum_o,
  output logic [WIDTH-1:0]        carry_o,
  output logic [WIDTH-1:0]        prod_o
);

  localparam int unsigned TW = ROWS * WIDTH;

  function automatic int unsigned rows_after(input int unsigned n);
    int unsigned r;
    r = ROWS;
    for (int i = 0; i < int'(n); i++) begin
      if (r > 2) r = r - r / 3;
    end
    return r;
  endfunction

  function automatic int unsigned count_levels();
    int unsigned r;
    int unsigned l;
    r = ROWS;
    l = 0;
    for (int i = 0; i < int'(ROWS); i++) begin
      if (r > 2) begin
        r = r - r / 3;
        l = l + 1;
      end
    end
    return l;
  endfunction

  localparam int unsigned L  = count_levels();
  localparam int unsigned S  = (L == 0) ? 1 : (L + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;
  localparam int unsigned NS = S + FINAL_ADD;

  // Apply n 3:2 levels to an r_in-row list; rows past the live count come back as zero.
  function automatic logic [TW-1:0] reduce(input logic [TW-1:0] x_in, input int r_in, input int n);
    logic [TW-1:0]    x;
    logic [TW-1:0]    y;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    int               r;
    int               t;
    x = x_in;
    r = r_in;
    for (int lv = 0; lv < int'(ROWS); lv++) begin
      if (lv < n && r > 2) begin
        t = r / 3;
        y = '0;
        for (int i = 0; i < int'(ROWS / 3); i++) begin
          if (i < t) begin
            a = x[3*i*WIDTH +: WIDTH];
            b = x[(3*i+1)*WIDTH +: WIDTH];
            c = x[(3*i+2)*WIDTH +: WIDTH];
            y[2*i*WIDTH +: WIDTH]     = a ^ b ^ c;
            y[(2*i+1)*WIDTH +: WIDTH] = ((a & b) | (a & c) | (b & c)) << 1;
          end
        end
        for (int k = 0; k < 2; k++) begin
          if (k < r % 3) y[(2*t+k)*WIDTH +: WIDTH] = x[(3*t+k)*WIDTH +: WIDTH];
        end
        x = y;
        r = r - t;
      end
    end
    return x;
  endfunction

  logic [NS-1:0] vld;
  logic [NS-1:0] ld;
  logic [NS-1:0] vin;
  logic          acc;

  // Load enables ripple back from the consumer; a stage loads if it or any later stage has room.
  always_comb begin
    ld  = '0;
    vin = '0;
    acc = out_ready;
    for (int j = int'(NS) - 1; j >= 0; j--) begin
      acc   = acc | ~vld[j];
      ld[j] = acc;
    end
    vin[0] = in_valid;
    for (int j = 1; j < int'(NS); j++) vin[j] = vld[j-1];
  end

  assign in_ready  = ld[0] & ~rst;
  assign out_valid = vld[NS-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      for (int j = 0; j < int'(NS); j++) begin
        if (ld[j]) vld[j] <= vin[j];
      end
    end
  end

  for (genvar j = 0; j < S; j++) begin : g_stg
    localparam int unsigned LV_IN  = j * LEVELS_PER_STAGE;
    localparam int unsigned LV_OUT = ((j + 1) * LEVELS_PER_STAGE < L) ? (j + 1) * LEVELS_PER_STAGE : L;
    localparam int unsigned R_IN   = rows_after(LV_IN);
    localparam int unsigned R_OUT  = rows_after(LV_OUT);
    localparam int unsigned IW     = R_IN * WIDTH;
    localparam int unsigned OW     = R_OUT * WIDTH;

    logic [IW-1:0] src;
    logic [OW-1:0] data;

    if (j == 0) begin : g_src0
      assign src = rows_i;
    end else begin : g_srcn
      assign src = g_stg[j-1].data;
    end

    // Data moves only with a valid token so held results survive rejected bubbles.
    always_ff @(posedge clk) begin
      if (rst) begin
        data <= '0;
      end else if (ld[j] && vin[j]) begin
        data <= OW'(reduce(TW'(src), int'(R_IN), int'(LV_OUT - LV_IN)));
      end
    end
  end

  logic [2*WIDTH-1:0] red;
  assign red = g_stg[S-1].data;

  if (FINAL_ADD != 0) begin : g_fa
    always_ff @(posedge clk) begin
      if (rst) begin
        sum_o   <= '0;
        carry_o <= '0;
        prod_o  <= '0;
      end else if (ld[NS-1] && vin[NS-1]) begin
        sum_o   <= red[WIDTH-1:0];
        carry_o <= red[2*WIDTH-1:WIDTH];
        prod_o  <= red[WIDTH-1:0] + red[2*WIDTH-1:WIDTH];
      end
    end
  end else begin : g_nofa
    assign sum_o   = red[WIDTH-1:0];
    assign carry_o = red[2*WIDTH-1:WIDTH];
    assign prod_o  = '0;
  end

endmodule

// File: tb/tb_csa_reduce_pipe.sv
// Directed and scoreboarded checks of csa_reduce_pipe in four parameter configurations.
module tb_csa_reduce_pipe;
  localparam int unsigned W = 48;
  localparam int unsigned R = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           iv;
  logic           ordy;
  logic [R*W-1:0] rows;

  logic d0_ir, d0_ov, d1_ir, d1_ov;
  logic [W-1:0] d0_s, d0_c, d0_p, d1_s, d1_c, d1_p;

  logic v3, u3_ir, u3_ov, v2, u2_ir, u2_ov;
  logic [23:0] r3;
  logic [15:0] r2;
  logic [7:0] u3_s, u3_c, u3_p, u2_s, u2_c, u2_p;

  csa_reduce_pipe #(.WIDTH(W), .ROWS(R), .LEVELS_PER_STAGE(2), .FINAL_ADD(0)) d0 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(d0_ir), .rows_i(rows),
    .out_valid(d0_ov), .out_ready(ordy), .sum_o(d0_s), .carry_o(d0_c), .prod_o(d0_p));

  csa_reduce_pipe #(.WIDTH(W), .ROWS(R), .LEVELS_PER_STAGE(2), .FINAL_ADD(1)) d1 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(d1_ir), .rows_i(rows),
    .out_valid(d1_ov), .out_ready(ordy), .sum_o(d1_s), .carry_o(d1_c), .prod_o(d1_p));

  csa_reduce_pipe #(.WIDTH(8), .ROWS(3), .LEVELS_PER_STAGE(2), .FINAL_ADD(1)) u3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(u3_ir), .rows_i(r3),
    .out_valid(u3_ov), .out_ready(ordy), .sum_o(u3_s), .carry_o(u3_c), .prod_o(u3_p));

  csa_reduce_pipe #(.WIDTH(8), .ROWS(2), .LEVELS_PER_STAGE(2), .FINAL_ADD(0)) u2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(u2_ir), .rows_i(r2),
    .out_valid(u2_ov), .out_ready(ordy), .sum_o(u2_s), .carry_o(u2_c), .prod_o(u2_p));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] ref_sum(input logic [R*W-1:0] x);
    logic [W-1:0] s;
    s = '0;
    for (int k = 0; k < int'(R); k++) s = s + x[k*W +: W];
    return s;
  endfunction

  task automatic rand_rows();
    for (int k = 0; k < int'(R); k++) rows[k*W +: W] = W'({$urandom(), $urandom()});
  endtask

  logic [W-1:0] q[$];
  logic [W-1:0] one48;
  int got, sent, cyc, acc_n, stale;
  bit acc;

  initial begin
    rst = 1'b1; iv = 1'b0; ordy = 1'b1; rows = '0;
    v3 = 1'b0; v2 = 1'b0; r3 = '0; r2 = '0;
    one48 = 48'h1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(d1_ov), 64'(0));
    check("rst_prod", 64'(d1_p), 64'(0));
    check("rst_in_ready_low", 64'(d1_ir), 64'(0));
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(d1_ir), 64'(1));

    // Small configurations: 3 rows of 0xFF, and a 2-row pass-through
    @(negedge clk);
    v3 = 1'b1; r3 = {8'hFF, 8'hFF, 8'hFF};
    v2 = 1'b1; r2 = {8'h34, 8'h12};
    @(negedge clk);
    v3 = 1'b0; v2 = 1'b0;
    check("u3_lat1_valid", 64'(u3_ov), 64'(0));
    check("u2_valid", 64'(u2_ov), 64'(1));
    check("u2_sum", 64'(u2_s), 64'h12);
    check("u2_carry", 64'(u2_c), 64'h34);
    check("u2_prod", 64'(u2_p), 64'h0);
    @(negedge clk);
    check("u3_valid", 64'(u3_ov), 64'(1));
    check("u3_sum", 64'(u3_s), 64'hFF);
    check("u3_carry", 64'(u3_c), 64'hFE);
    check("u3_prod", 64'(u3_p), 64'hFD);
    repeat (3) @(negedge clk);

    // Defaults: disjoint one-hot rows reduce without carries
    for (int k = 0; k < int'(R); k++) rows[k*W +: W] = one48 << (5 * k);
    iv = 1'b1;
    #1;
    check("d0_in_ready", 64'(d0_ir), 64'(1));
    @(negedge clk);
    iv = 1'b0;
    check("d0_lat1_valid", 64'(d0_ov), 64'(0));
    @(negedge clk);
    check("d0_lat2_valid", 64'(d0_ov), 64'(1));
    check("d0_sum", 64'(d0_s), 64'h0108_4210_8421);
    check("d0_carry", 64'(d0_c), 64'h0);
    @(negedge clk);
    for (int k = 0; k < int'(R); k++) rows[k*W +: W] = 48'hFFFF_FFFF_FFFF;
    iv = 1'b1;
    @(negedge clk);
    iv = 1'b0;
    @(negedge clk);
    check("d0_ones_valid", 64'(d0_ov), 64'(1));
    check("d0_ones_total", 64'(W'(d0_s + d0_c)), 64'hFFFF_FFFF_FFF7);
    repeat (4) @(negedge clk);

    // Random back-to-back traffic with random out_ready on the FINAL_ADD instance
    got = 0; sent = 0; cyc = 0; acc = 1'b1; q.delete();
    while (got < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (acc) rand_rows();
      ordy = 1'($urandom_range(0, 1));
      iv = (sent < 1000);
      #1;
      if (d1_ov && ordy) begin
        check("rand_result_expected", 64'(q.size() != 0), 64'(1));
        if (q.size() != 0) check("rand_prod", 64'(d1_p), 64'(q.pop_front()));
        got++;
      end
      acc = iv && d1_ir;
      if (acc) begin
        q.push_back(ref_sum(rows));
        sent++;
      end
    end
    check("rand_count", 64'(got), 64'(1000));
    check("rand_leftover", 64'(q.size()), 64'(0));
    @(negedge clk);
    iv = 1'b0; ordy = 1'b1;
    repeat (4) @(negedge clk);

    // Backpressure: only Lat=3 of 5 offered sets fit, outputs hold, then drain in order
    ordy = 1'b0; acc_n = 0; q.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rand_rows();
      iv = 1'b1;
      #1;
      if (d1_ir) begin
        q.push_back(ref_sum(rows));
        acc_n++;
      end
    end
    @(negedge clk);
    iv = 1'b0;
    check("bp_accepted", 64'(acc_n), 64'(3));
    check("bp_in_ready_low", 64'(d1_ir), 64'(0));
    check("bp_valid", 64'(d1_ov), 64'(1));
    check("bp_hold0", 64'(d1_p), 64'(q[0]));
    @(negedge clk);
    check("bp_hold1", 64'(d1_p), 64'(q[0]));
    ordy = 1'b1;
    got = 0; cyc = 0;
    while (q.size() != 0 && cyc < 20) begin
      #1;
      if (d1_ov) begin
        check("bp_drain", 64'(d1_p), 64'(q.pop_front()));
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    check("bp_drain_count", 64'(got), 64'(3));
    repeat (2) @(negedge clk);

    // Reset with a full pipe discards everything
    ordy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_rows();
      iv = 1'b1;
      @(negedge clk);
    end
    iv = 1'b0;
    check("full_before_rst", 64'(d1_ov), 64'(1));
    rst = 1'b1;
    #1;
    check("rst_in_ready", 64'(d1_ir), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 64'(d1_ov), 64'(0));
    check("mid_rst_sum", 64'(d1_s), 64'(0));
    check("mid_rst_carry", 64'(d1_c), 64'(0));
    check("mid_rst_prod", 64'(d1_p), 64'(0));
    check("mid_rst_in_ready", 64'(d1_ir), 64'(1));
    ordy = 1'b1;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (d1_ov) stale++;
    end
    check("no_stale", 64'(stale), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
